// File: rtl/uart_stim_tx.sv
// rtl/uart_stim_tx.sv - FIFO-fed UART transmitter driving a CoreUART RX line
// 8N1/8E1/8O1/8x2 framing, LSB first; frames run back-to-back while the FIFO holds data.
module uart_stim_tx #(
  parameter int BAUD_DIV   = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       SYSCLK,
  input  logic       NSYSRESET,
  input  logic [7:0] DATA_IN,
  input  logic       WEN,
  output logic       FULL,
  output logic       EMPTY,
  output logic       BUSY,
  output logic       WR_OVF,
  output logic       TX
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BAUD_DIV);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, empty_q, ovf_q, tx_q, busy_q, par_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [7:0]    head;
  logic          push, pop, baud_last, stop_last;

  assign head = mem_q[rd_ptr_q];

  // A write while full is refused even if the same edge pops a byte.
  always_comb begin
    push      = WEN && !full_q;
    baud_last = (baud_q == BW'(BAUD_DIV - 1));
    stop_last = (bit_q == 3'(STOP_BITS - 1));
    pop       = !empty_q && ((state_q == S_IDLE) ||
                             (state_q == S_STOP && baud_last && stop_last));
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge SYSCLK) begin
    if (push) mem_q[wr_ptr_q] <= DATA_IN;
  end

  always_ff @(posedge SYSCLK) begin
    if (!NSYSRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(FIFO_DEPTH));
      empty_q <= (cnt_d == '0);
      ovf_q   <= WEN && full_q;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (!NSYSRESET) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (pop) begin
        state_q <= S_START;
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
        baud_q  <= '0;
        shift_q <= head;
        par_q   <= (^head) ^ (PARITY_ODD != 0);
      end
    end else if (!baud_last) begin
      baud_q <= baud_q + 1'b1;
    end else begin
      baud_q <= '0;
      case (state_q)
        S_START: begin
          state_q <= S_DATA;
          tx_q    <= shift_q[0];
          bit_q   <= '0;
        end
        S_DATA: begin
          if (bit_q == 3'd7) begin
            bit_q <= '0;
            if (PARITY_EN != 0) begin
              state_q <= S_PARITY;
              tx_q    <= par_q;
            end else begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end
          end else begin
            bit_q   <= bit_q + 1'b1;
            shift_q <= shift_q >> 1;
            tx_q    <= shift_q[1];
          end
        end
        S_PARITY: begin
          state_q <= S_STOP;
          tx_q    <= 1'b1;
          bit_q   <= '0;
        end
        S_STOP: begin
          if (!stop_last) begin
            bit_q <= bit_q + 1'b1;
          end else if (pop) begin
            // Chain straight into the next frame without an idle bit.
            state_q <= S_START;
            tx_q    <= 1'b0;
            bit_q   <= '0;
            shift_q <= head;
            par_q   <= (^head) ^ (PARITY_ODD != 0);
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            bit_q   <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign FULL   = full_q;
  assign EMPTY  = empty_q;
  assign BUSY   = busy_q;
  assign WR_OVF = ovf_q;
  assign TX     = tx_q;

endmodule

// File: tb/tb_uart_stim_tx.sv
// tb/tb_uart_stim_tx.sv - directed self-checking bench for uart_stim_tx
// Four instances cover 8N1, even/odd parity and two stop bits.
module tb_uart_stim_tx;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] din = 8'h00;
  logic       wen [4];
  logic       tx [4], busy [4], full [4], empty [4], ovf [4];
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  uart_stim_tx #(.BAUD_DIV(4)) u_a (
    .SYSCLK(clk), .NSYSRESET(rstn), .DATA_IN(din), .WEN(wen[0]),
    .FULL(full[0]), .EMPTY(empty[0]), .BUSY(busy[0]), .WR_OVF(ovf[0]), .TX(tx[0]));
  uart_stim_tx #(.BAUD_DIV(4), .PARITY_EN(1)) u_b (
    .SYSCLK(clk), .NSYSRESET(rstn), .DATA_IN(din), .WEN(wen[1]),
    .FULL(full[1]), .EMPTY(empty[1]), .BUSY(busy[1]), .WR_OVF(ovf[1]), .TX(tx[1]));
  uart_stim_tx #(.BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(1)) u_c (
    .SYSCLK(clk), .NSYSRESET(rstn), .DATA_IN(din), .WEN(wen[2]),
    .FULL(full[2]), .EMPTY(empty[2]), .BUSY(busy[2]), .WR_OVF(ovf[2]), .TX(tx[2]));
  uart_stim_tx #(.BAUD_DIV(8), .STOP_BITS(2)) u_d (
    .SYSCLK(clk), .NSYSRESET(rstn), .DATA_IN(din), .WEN(wen[3]),
    .FULL(full[3]), .EMPTY(empty[3]), .BUSY(busy[3]), .WR_OVF(ovf[3]), .TX(tx[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // bits[0] is the start bit; each bit must hold for div cycles with BUSY high.
  task automatic check_frame(input int w, input string tag, input logic [11:0] bits,
                             input int nbits, input int div);
    for (int i = 0; i < nbits * div; i++) begin
      check($sformatf("%s tx[%0d]", tag, i), {31'd0, tx[w]}, {31'd0, bits[i / div]});
      check($sformatf("%s busy[%0d]", tag, i), {31'd0, busy[w]}, 32'd1);
      tick();
    end
  endtask

  task automatic check_idle(input int w, input string tag);
    check({tag, " idle tx"}, {31'd0, tx[w]}, 32'd1);
    check({tag, " idle busy"}, {31'd0, busy[w]}, 32'd0);
    check({tag, " idle empty"}, {31'd0, empty[w]}, 32'd1);
  endtask

  task automatic single_byte(input int w, input string tag, input logic [7:0] b,
                             input logic [11:0] bits, input int nbits, input int div);
    din = b;
    wen[w] = 1'b1;
    tick();
    wen[w] = 1'b0;
    check({tag, " empty after write"}, {31'd0, empty[w]}, 32'd0);
    check({tag, " tx idle at write edge"}, {31'd0, tx[w]}, 32'd1);
    tick();
    check({tag, " empty after pop"}, {31'd0, empty[w]}, 32'd1);
    check_frame(w, tag, bits, nbits, div);
    check_idle(w, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) wen[k] = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst tx%0d", k), {31'd0, tx[k]}, 32'd1);
      check($sformatf("rst busy%0d", k), {31'd0, busy[k]}, 32'd0);
      check($sformatf("rst full%0d", k), {31'd0, full[k]}, 32'd0);
      check($sformatf("rst empty%0d", k), {31'd0, empty[k]}, 32'd1);
      check($sformatf("rst ovf%0d", k), {31'd0, ovf[k]}, 32'd0);
    end
    rstn = 1'b1;
    tick();

    single_byte(0, "b55", 8'h55, 12'h2AA, 10, 4);
    single_byte(1, "par_even", 8'h07, 12'h60E, 11, 4);
    single_byte(2, "par_odd", 8'h07, 12'h40E, 11, 4);

    // Overflow: A0..A5 on consecutive edges, A5 must be dropped.
    fork
      begin
        wen[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
          din = 8'hA0 + 8'(i);
          tick();
          if (i == 3) check("ovf not full yet", {31'd0, full[0]}, 32'd0);
          if (i == 4) check("ovf full", {31'd0, full[0]}, 32'd1);
          if (i == 4) check("ovf no pulse yet", {31'd0, ovf[0]}, 32'd0);
          if (i == 5) check("ovf pulse", {31'd0, ovf[0]}, 32'd1);
        end
        wen[0] = 1'b0;
        tick();
        check("ovf pulse one cycle", {31'd0, ovf[0]}, 32'd0);
        check("ovf still full", {31'd0, full[0]}, 32'd1);
      end
      begin
        tick();
        tick();
        check_frame(0, "fA0", 12'h340, 10, 4);
        check_frame(0, "fA1", 12'h342, 10, 4);
        check_frame(0, "fA2", 12'h344, 10, 4);
        check_frame(0, "fA3", 12'h346, 10, 4);
        check_frame(0, "fA4", 12'h348, 10, 4);
        check_idle(0, "ovf");
      end
    join

    // Two stop bits: 16 cycles of mark between frames.
    din = 8'hFF;
    wen[3] = 1'b1;
    tick();
    din = 8'h00;
    tick();
    wen[3] = 1'b0;
    check_frame(3, "sFF", 12'h7FE, 11, 8);
    check_frame(3, "s00", 12'h600, 11, 8);
    check_idle(3, "stop2");

    // Reset during data bit 3 of 0x3C with two bytes still queued.
    wen[0] = 1'b1;
    din = 8'h3C;
    tick();
    din = 8'h11;
    tick();
    din = 8'h22;
    tick();
    wen[0] = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    check("mid bit3 tx", {31'd0, tx[0]}, 32'd1);
    check("mid busy", {31'd0, busy[0]}, 32'd1);
    check("mid queued", {31'd0, empty[0]}, 32'd0);
    rstn = 1'b0;
    tick();
    check("rst mid tx", {31'd0, tx[0]}, 32'd1);
    check("rst mid busy", {31'd0, busy[0]}, 32'd0);
    check("rst mid empty", {31'd0, empty[0]}, 32'd1);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post rst quiet", {31'd0, tx[0]}, 32'd1);
    end
    single_byte(0, "b81", 8'h81, 12'h302, 10, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
